// File: rtl/dwa_element_selector_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dwa_element_selector_pkg
//  Brief    : Shared constants and types for the DEM element selector.
//  Revision : 1.0 - initial release
// ============================================================================
package dwa_element_selector_pkg;

    localparam int OUTPUT_WIDTH = 4;
    localparam int NUM_ELEM     = 2**OUTPUT_WIDTH - 1;
    localparam int PTR_WIDTH    = $clog2(NUM_ELEM);

    typedef enum logic {
        DEM_THERM = 1'b0,
        DEM_DWA   = 1'b1
    } dem_mode_e;

    typedef logic [NUM_ELEM-1:0] elem_vec_t;

endpackage
`default_nettype wire

// File: rtl/dwa_element_selector_therm_rotator.sv
`default_nettype none
// ============================================================================
//  Module   : dwa_element_selector_therm_rotator
//  Brief    : Combinational thermometer mask of n ones, rotated left by b.
//  Revision : 1.0 - initial release
// ============================================================================
module dwa_element_selector_therm_rotator
#(
    parameter int CODE_WIDTH = 4,
    parameter int NUM_ELEM   = 15,
    parameter int PTR_WIDTH  = $clog2(NUM_ELEM)
) (
    input  logic [CODE_WIDTH-1:0] n_i,
    input  logic [PTR_WIDTH-1:0]  b_i,
    output logic [NUM_ELEM-1:0]   rot_o
);

    logic [NUM_ELEM-1:0]   mask;
    logic [2*NUM_ELEM-1:0] dbl;

    for (genvar k = 0; k < NUM_ELEM; k++) begin : g_mask
        assign mask[k] = (n_i > CODE_WIDTH'(k));
    end

    // Bits pushed past the top of the doubled word fold back onto element 0 upward.
    assign dbl   = {mask, mask} << b_i;
    assign rot_o = dbl[2*NUM_ELEM-1:NUM_ELEM] | dbl[NUM_ELEM-1:0];

endmodule
`default_nettype wire

// File: rtl/dwa_element_selector.sv
`default_nettype none
// ============================================================================
//  Module   : dwa_element_selector
//  Brief    : Maps quantizer level codes to DAC unit-element enables (DWA/therm).
//  Revision : 1.0 - initial release
// ============================================================================
module dwa_element_selector
    import dwa_element_selector_pkg::*;
#(
    parameter int CODE_WIDTH = OUTPUT_WIDTH,
    parameter int NUM_ELEM   = 2**CODE_WIDTH - 1
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        valid_i,
    input  logic [CODE_WIDTH-1:0]       code_i,
    input  logic                        mode_i,
    input  logic                        clear_ptr_i,
    output logic [NUM_ELEM-1:0]         elem_sel_o,
    output logic                        valid_o,
    output logic [$clog2(NUM_ELEM)-1:0] ptr_o,
    output logic                        clip_o
);

    localparam int PTR_WIDTH = $clog2(NUM_ELEM);
    localparam int SUM_W     = PTR_WIDTH + 1;
    localparam logic [CODE_WIDTH-1:0] C_NUM_CODE = CODE_WIDTH'(NUM_ELEM);
    localparam logic [SUM_W-1:0]      C_NUM_SUM  = SUM_W'(NUM_ELEM);

    dem_mode_e              mode;
    logic                   clip;
    logic [CODE_WIDTH-1:0]  n;
    logic [PTR_WIDTH-1:0]   base;
    logic [SUM_W-1:0]       sum;
    logic [PTR_WIDTH-1:0]   ptr_wrap;
    logic [NUM_ELEM-1:0]    rot_mask;

    logic [NUM_ELEM-1:0]    elem_q, elem_d;
    logic                   valid_q;
    logic                   clip_q, clip_d;
    logic [PTR_WIDTH-1:0]   ptr_q, ptr_d;

    assign mode = dem_mode_e'(mode_i);
    assign clip = (code_i > C_NUM_CODE);
    assign n    = clip ? C_NUM_CODE : code_i;
    assign base = clear_ptr_i ? '0 : ptr_q;

    // b < NUM_ELEM and n <= NUM_ELEM, so one conditional subtract reduces the sum.
    assign sum      = SUM_W'(base) + SUM_W'(n);
    assign ptr_wrap = (sum >= C_NUM_SUM) ? PTR_WIDTH'(sum - C_NUM_SUM) : PTR_WIDTH'(sum);

    dwa_element_selector_therm_rotator #(
        .CODE_WIDTH (CODE_WIDTH),
        .NUM_ELEM   (NUM_ELEM),
        .PTR_WIDTH  (PTR_WIDTH)
    ) u_rot (
        .n_i   (n),
        .b_i   ((mode == DEM_DWA) ? base : '0),
        .rot_o (rot_mask)
    );

    always_comb begin
        elem_d = elem_q;
        clip_d = clip_q;
        ptr_d  = clear_ptr_i ? '0 : ptr_q;
        if (valid_i) begin
            elem_d = rot_mask;
            clip_d = clip;
            ptr_d  = (mode == DEM_DWA) ? ptr_wrap : '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            elem_q  <= '0;
            valid_q <= 1'b0;
            clip_q  <= 1'b0;
            ptr_q   <= '0;
        end else begin
            elem_q  <= elem_d;
            valid_q <= valid_i;
            clip_q  <= clip_d;
            ptr_q   <= ptr_d;
        end
    end

    assign elem_sel_o = elem_q;
    assign valid_o    = valid_q;
    assign clip_o     = clip_q;
    assign ptr_o      = ptr_q;

    a_ptr_range: assert property (@(posedge clk_i) disable iff (rst_i) int'(ptr_q) < NUM_ELEM);

endmodule
`default_nettype wire

// File: tb/tb_dwa_element_selector.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dwa_element_selector
//  Brief    : Vector-table bench for the element selector (15- and 12-element builds).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dwa_element_selector;

    typedef struct {
        logic        v;
        logic [3:0]  code;
        logic        mode;
        logic        clr;
        logic [14:0] sel;
        logic        ov;
        logic [3:0]  ptr;
        logic        clip;
        logic        d12;
    } vec_t;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        valid_i = 1'b0;
    logic [3:0]  code_i = '0;
    logic        mode_i = 1'b0;
    logic        clear_ptr_i = 1'b0;

    logic [14:0] sel15;
    logic        v15, clip15;
    logic [3:0]  ptr15;
    logic [11:0] sel12;
    logic        v12, clip12;
    logic [3:0]  ptr12;

    int checks = 0;
    int errors = 0;
    vec_t sb[$];
    vec_t t12[4];
    vec_t t15[15];

    always #5 clk_i = ~clk_i;

    dwa_element_selector u15 (
        .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .code_i(code_i),
        .mode_i(mode_i), .clear_ptr_i(clear_ptr_i),
        .elem_sel_o(sel15), .valid_o(v15), .ptr_o(ptr15), .clip_o(clip15)
    );

    dwa_element_selector #(.CODE_WIDTH(4), .NUM_ELEM(12)) u12 (
        .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .code_i(code_i),
        .mode_i(mode_i), .clear_ptr_i(clear_ptr_i),
        .elem_sel_o(sel12), .valid_o(v12), .ptr_o(ptr12), .clip_o(clip12)
    );

    function automatic vec_t mk(logic v, logic [3:0] code, logic mode, logic clr,
                                logic [14:0] sel, logic ov, logic [3:0] ptr,
                                logic clip, logic d12);
        vec_t r;
        r.v = v; r.code = code; r.mode = mode; r.clr = clr;
        r.sel = sel; r.ov = ov; r.ptr = ptr; r.clip = clip; r.d12 = d12;
        return r;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%h expected 0x%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare(input vec_t e);
        if (e.d12) begin
            chk("sel12",  {4'b0, sel12},  {1'b0, e.sel});
            chk("valid12", {15'b0, v12},  {15'b0, e.ov});
            chk("ptr12",  {12'b0, ptr12}, {12'b0, e.ptr});
            chk("clip12", {15'b0, clip12}, {15'b0, e.clip});
        end else begin
            chk("sel15",  {1'b0, sel15},  {1'b0, e.sel});
            chk("valid15", {15'b0, v15},  {15'b0, e.ov});
            chk("ptr15",  {12'b0, ptr15}, {12'b0, e.ptr});
            chk("clip15", {15'b0, clip15}, {15'b0, e.clip});
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_sel15"}, {1'b0, sel15}, 16'h0);
        chk({tag, "_misc15"}, {11'b0, v15, ptr15}, 16'h0);
        chk({tag, "_clip15"}, {15'b0, clip15}, 16'h0);
        chk({tag, "_sel12"}, {4'b0, sel12}, 16'h0);
        chk({tag, "_misc12"}, {11'b0, v12, ptr12, clip12} >> 0, 16'h0);
    endtask

    task automatic step(input vec_t v);
        @(negedge clk_i);
        if (sb.size() > 0) compare(sb.pop_front());
        valid_i     = v.v;
        code_i      = v.code;
        mode_i      = v.mode;
        clear_ptr_i = v.clr;
        sb.push_back(v);
    endtask

    task automatic flush();
        @(negedge clk_i);
        if (sb.size() > 0) compare(sb.pop_front());
        valid_i     = 1'b0;
        clear_ptr_i = 1'b0;
    endtask

    initial begin
        // 12-element build: clamp, clip hold across a gap, wrap at 12
        t12[0] = mk(1, 4'd14, 1, 0, 15'h0FFF, 1, 4'd0, 1, 1);
        t12[1] = mk(0, 4'd0,  1, 0, 15'h0FFF, 0, 4'd0, 1, 1);
        t12[2] = mk(1, 4'd3,  1, 0, 15'h0007, 1, 4'd3, 0, 1);
        t12[3] = mk(1, 4'd11, 1, 0, 15'h0FFB, 1, 4'd2, 0, 1);

        // 15-element build: DWA rotation, full/empty codes, clear, gaps, therm mode
        t15[0]  = mk(1, 4'd5,  1, 0, 15'h001F, 1, 4'd5,  0, 0);
        t15[1]  = mk(1, 4'd5,  1, 0, 15'h03E0, 1, 4'd10, 0, 0);
        t15[2]  = mk(1, 4'd7,  1, 0, 15'h7C03, 1, 4'd2,  0, 0);
        t15[3]  = mk(1, 4'd15, 1, 0, 15'h7FFF, 1, 4'd2,  0, 0);
        t15[4]  = mk(1, 4'd0,  1, 0, 15'h0000, 1, 4'd2,  0, 0);
        t15[5]  = mk(1, 4'd8,  1, 0, 15'h03FC, 1, 4'd10, 0, 0);
        t15[6]  = mk(1, 4'd6,  1, 1, 15'h003F, 1, 4'd6,  0, 0);
        t15[7]  = mk(0, 4'd9,  1, 0, 15'h003F, 0, 4'd6,  0, 0);
        t15[8]  = mk(0, 4'd2,  0, 0, 15'h003F, 0, 4'd6,  0, 0);
        t15[9]  = mk(1, 4'd3,  0, 0, 15'h0007, 1, 4'd0,  0, 0);
        t15[10] = mk(1, 4'd9,  0, 0, 15'h01FF, 1, 4'd0,  0, 0);
        t15[11] = mk(1, 4'd4,  1, 0, 15'h000F, 1, 4'd4,  0, 0);
        t15[12] = mk(0, 4'd0,  1, 1, 15'h000F, 0, 4'd0,  0, 0);
        t15[13] = mk(1, 4'd3,  1, 0, 15'h0007, 1, 4'd3,  0, 0);
        t15[14] = mk(1, 4'd14, 1, 0, 15'h7FFB, 1, 4'd2,  0, 0);

        repeat (2) @(negedge clk_i);
        check_zero("por");
        rst_i = 1'b0;

        foreach (t12[i]) step(t12[i]);
        flush();

        // Reset mid-stream: outputs must clear without waiting for a clock edge
        @(negedge clk_i);
        valid_i = 1'b1; code_i = 4'd9; mode_i = 1'b1; clear_ptr_i = 1'b0;
        @(posedge clk_i);
        #2 rst_i = 1'b1;
        #1 check_zero("async_rst");
        @(negedge clk_i);
        valid_i = 1'b0;
        rst_i   = 1'b0;

        foreach (t15[i]) step(t15[i]);
        flush();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
